stream_mux_rr: RTL and testbench

Parametrised N-channel, W-bit-wide successor to the single-bit 2:1 Multiplexer. It selects one of CHANNELS valid/ready input streams and forwards the selected word into a registered output stage. It has two modes: explicit-select, where SEL chooses the channel, and round-robin, where an internal rotating pointer chooses it. It sits between multiple producers and a single consumer in the datapath.

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/rr_pick.sv | 37 +++
 rtl/stream_mux_rr.sv | 123 ++++++++++++
 tb/tb_stream_mux_rr.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the valid/ready stream multiplexer.
// Mode encodings and the select-width helper live here so sub-blocks agree.
package stream_mux_pkg;

    localparam int MODE_SELECT = 0;
    localparam int MODE_RR     = 1;

    // A 1-channel mux still needs a 1-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first asserted request at or after ptr_i, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_pick
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SEL_W-1:0]    ptr_i,
    output logic [SEL_W-1:0]    gnt_idx_o,
    output logic                gnt_valid_o
);

    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(CHANNELS)) begin
                sum = sum - (SEL_W+1)'(CHANNELS);
            end
            idx = sum[SEL_W-1:0];
            if (req_i[idx]) begin
                gnt_idx_o   = idx;
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with a registered output stage.
// MODE 0 grants the channel named by SEL; MODE 1 arbitrates round-robin.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_SELECT,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
    input  logic [CHANNELS-1:0]       IN_VALID,
    output logic [CHANNELS-1:0]       IN_READY,
    input  logic [SEL_W-1:0]          SEL,
    output logic [WIDTH-1:0]          OUT_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [SEL_W-1:0]          OUT_CH
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q,   out_ch_d;
    logic             out_valid_q, out_valid_d;

    logic             load_en;
    logic             xfer;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;

    assign load_en = !out_valid_q || OUT_READY;
    assign xfer    = load_en && grant_valid && !RST;

    if (MODE == MODE_RR) begin : g_rr
        logic [SEL_W-1:0] ptr_q, ptr_d;
        logic             unused_sel;

        assign unused_sel = ^SEL;

        rr_pick #(
            .CHANNELS (CHANNELS),
            .SEL_W    (SEL_W)
        ) u_pick (
            .req_i       (IN_VALID),
            .ptr_i       (ptr_q),
            .gnt_idx_o   (grant_idx),
            .gnt_valid_o (grant_valid)
        );

        // Explicit compare keeps the wrap right for non-power-of-two CHANNELS.
        always_comb begin
            ptr_d = ptr_q;
            if (xfer) begin
                ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end else begin : g_sel
        always_comb begin
            grant_idx   = SEL;
            grant_valid = 1'b0;
            if ({1'b0, SEL} < (SEL_W+1)'(CHANNELS)) begin
                grant_valid = IN_VALID[SEL];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = IN_DATA[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        IN_READY = '0;
        if (xfer) begin
            IN_READY[grant_idx] = 1'b1;
        end
    end

    // Without a grant the slot empties but the last word and channel are kept.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (load_en) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = grant_data;
                out_ch_d   = grant_idx;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_CH    = out_ch_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: three instances (select/4ch, round-robin/4ch, round-robin/3ch)
// checked against a transaction-level model of the grant and output-slot rules.
module tb_stream_mux_rr;

    logic        CLK = 1'b0;
    logic        RST;

    logic [3:0]  t_v    [3];
    logic [31:0] t_data [3];
    logic [1:0]  t_sel  [3];
    logic        t_rdy  [3];

    logic [23:0] data2;
    logic [2:0]  valid2;
    assign data2  = t_data[2][23:0];
    assign valid2 = t_v[2][2:0];

    logic [3:0] ir0, ir1;
    logic [2:0] ir2;
    logic [7:0] od0, od1, od2;
    logic       ov0, ov1, ov2;
    logic [1:0] och0, och1, och2;

    logic       m_valid [3];
    logic [7:0] m_data  [3];
    int         m_ch    [3];
    int         m_ptr   [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u0 (
        .CLK(CLK), .RST(RST), .IN_DATA(t_data[0]), .IN_VALID(t_v[0]), .IN_READY(ir0),
        .SEL(t_sel[0]), .OUT_DATA(od0), .OUT_VALID(ov0), .OUT_READY(t_rdy[0]), .OUT_CH(och0));

    stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u1 (
        .CLK(CLK), .RST(RST), .IN_DATA(t_data[1]), .IN_VALID(t_v[1]), .IN_READY(ir1),
        .SEL(t_sel[1]), .OUT_DATA(od1), .OUT_VALID(ov1), .OUT_READY(t_rdy[1]), .OUT_CH(och1));

    stream_mux_rr #(.WIDTH(8), .CHANNELS(3), .MODE(1)) u2 (
        .CLK(CLK), .RST(RST), .IN_DATA(data2), .IN_VALID(valid2), .IN_READY(ir2),
        .SEL(t_sel[2]), .OUT_DATA(od2), .OUT_VALID(ov2), .OUT_READY(t_rdy[2]), .OUT_CH(och2));

    function automatic int n_ch(int d);
        return (d == 2) ? 3 : 4;
    endfunction

    function automatic logic [3:0] obs_ready(int d);
        case (d)
            0: return ir0;
            1: return ir1;
            default: return {1'b0, ir2};
        endcase
    endfunction

    function automatic logic [7:0] obs_data(int d);
        case (d)
            0: return od0;
            1: return od1;
            default: return od2;
        endcase
    endfunction

    function automatic logic obs_valid(int d);
        case (d)
            0: return ov0;
            1: return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic [1:0] obs_ch(int d);
        case (d)
            0: return och0;
            1: return och1;
            default: return och2;
        endcase
    endfunction

    // Model: which channel wins this cycle, or -1 for none.
    function automatic int exp_grant(int d);
        int c;
        c = n_ch(d);
        if (RST) return -1;
        if (d == 0) begin
            if (int'(t_sel[d]) < c && t_v[d][t_sel[d]]) return int'(t_sel[d]);
            return -1;
        end
        for (int k = 0; k < c; k++) begin
            if (t_v[d][(m_ptr[d] + k) % c]) return (m_ptr[d] + k) % c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(int d);
        int g;
        g = exp_grant(d);
        if ((!m_valid[d] || t_rdy[d]) && g >= 0) return 4'b0001 << g;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = 8'h00;
            m_ch[d]    = 0;
            m_ptr[d]   = 0;
        end
    endtask

    task automatic model_step();
        int g;
        for (int d = 0; d < 3; d++) begin
            g = exp_grant(d);
            if (!m_valid[d] || t_rdy[d]) begin
                if (g >= 0) begin
                    m_data[d]  = t_data[d][g*8 +: 8];
                    m_ch[d]    = g;
                    m_valid[d] = 1'b1;
                    if (d != 0) m_ptr[d] = (g + 1) % n_ch(d);
                end else begin
                    m_valid[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        for (int d = 0; d < 3; d++) begin
            t_v[d]    = 4'b0000;
            t_data[d] = 32'h0;
            t_sel[d]  = 2'd0;
            t_rdy[d]  = 1'b1;
        end
    endtask

    task automatic test_reset();
        set_idle();
        for (int d = 0; d < 3; d++) t_v[d] = 4'b1111;
        RST = 1'b1;
        model_reset();
        @(negedge CLK);
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_valid(d) !== 1'b0 || obs_data(d) !== 8'h00 || obs_ch(d) !== 2'd0 || obs_ready(d) !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_init dut%0d: got v=%b d=%h ch=%0d rdy=%b want v=0 d=00 ch=0 rdy=0000",
                         d, obs_valid(d), obs_data(d), obs_ch(d), obs_ready(d));
            end
        end
        set_idle();
        RST = 1'b0;
        t_v[0] = 4'b0001; t_data[0] = 32'h000000A5; t_sel[0] = 2'd0;
        tick();
        n_cmp++;
        if (od0 !== 8'hA5 || ov0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_preload: got d=%h v=%b want d=a5 v=1", od0, ov0);
        end
        for (int d = 0; d < 3; d++) t_v[d] = 4'b1111;
        t_rdy[0] = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_valid(d) !== 1'b0 || obs_data(d) !== 8'h00 || obs_ch(d) !== 2'd0 || obs_ready(d) !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_midop dut%0d: got v=%b d=%h ch=%0d rdy=%b want v=0 d=00 ch=0 rdy=0000",
                         d, obs_valid(d), obs_data(d), obs_ch(d), obs_ready(d));
            end
        end
        model_reset();
        set_idle();
        @(negedge CLK);
        RST = 1'b0;
        tick();
    endtask

    task automatic test_sel_basic();
        set_idle();
        t_sel[0] = 2'd2; t_v[0] = 4'b0100; t_data[0] = 32'h003C0000;
        @(negedge CLK);
        n_cmp++;
        if (ir0 !== 4'b0100 || exp_ready(0) !== 4'b0100) begin
            n_err++;
            $display("FAIL sel_basic_ready: got %b want 0100", ir0);
        end
        tick();
        n_cmp++;
        if (od0 !== 8'h3C || och0 !== 2'd2 || ov0 !== 1'b1) begin
            n_err++;
            $display("FAIL sel_basic_out: got d=%h ch=%0d v=%b want d=3c ch=2 v=1", od0, och0, ov0);
        end
    endtask

    task automatic test_sel_unselected();
        set_idle();
        t_sel[0] = 2'd1; t_v[0] = 4'b1000; t_data[0] = 32'h77000000;
        @(negedge CLK);
        n_cmp++;
        if (ir0 !== 4'b0000) begin
            n_err++;
            $display("FAIL sel_unselected_ready: got %b want 0000", ir0);
        end
        tick();
        n_cmp++;
        if (ov0 !== 1'b0 || od0 !== 8'h3C || och0 !== 2'd2) begin
            n_err++;
            $display("FAIL sel_unselected_out: got v=%b d=%h ch=%0d want v=0 d=3c ch=2", ov0, od0, och0);
        end
    endtask

    task automatic test_rr_fairness();
        set_idle();
        t_v[1] = 4'b1111;
        t_data[1] = $urandom;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (och1 !== 2'(i % 4) || ov1 !== 1'b1 || od1 !== t_data[1][(i%4)*8 +: 8]) begin
                n_err++;
                $display("FAIL rr_fair step%0d: got ch=%0d v=%b d=%h want ch=%0d v=1 d=%h",
                         i, och1, ov1, od1, i % 4, t_data[1][(i%4)*8 +: 8]);
            end
        end
    endtask

    task automatic test_rr_skip_wrap();
        logic [3:0] v1_seq [4];
        int         ch1_seq [4];
        int         ch2_seq [4];
        v1_seq  = '{4'b0100, 4'b0011, 4'b0011, 4'b0011};
        ch1_seq = '{2, 0, 1, 0};
        ch2_seq = '{2, 0, 1, 2};
        set_idle();
        for (int i = 0; i < 4; i++) begin
            t_v[1] = v1_seq[i];
            t_v[2] = (i == 0) ? 4'b0100 : 4'b0111;
            t_data[1] = $urandom;
            t_data[2] = $urandom;
            tick();
            n_cmp++;
            if (och1 !== 2'(ch1_seq[i]) || ov1 !== 1'b1) begin
                n_err++;
                $display("FAIL rr_skip4 step%0d: got ch=%0d v=%b want ch=%0d v=1", i, och1, ov1, ch1_seq[i]);
            end
            n_cmp++;
            if (och2 !== 2'(ch2_seq[i]) || ov2 !== 1'b1) begin
                n_err++;
                $display("FAIL rr_wrap3 step%0d: got ch=%0d v=%b want ch=%0d v=1", i, och2, ov2, ch2_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0, d1;
        set_idle();
        t_v[0] = 4'b0001; t_data[0] = 32'h00000011; t_sel[0] = 2'd0;
        t_v[1] = 4'b0001; t_data[1] = 32'h00000011;
        tick();
        for (int i = 0; i < 3; i++) begin
            t_rdy[0] = 1'b0; t_rdy[1] = 1'b0;
            t_v[0] = 4'($urandom_range(1, 15)); t_v[1] = 4'($urandom_range(1, 15));
            t_data[0] = $urandom; t_data[1] = $urandom;
            t_sel[0] = 2'($urandom_range(0, 3));
            @(negedge CLK);
            n_cmp++;
            if (ir0 !== 4'b0000 || ir1 !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_ready cyc%0d: got u0=%b u1=%b want 0000", i, ir0, ir1);
            end
            tick();
            n_cmp++;
            if (od0 !== 8'h11 || ov0 !== 1'b1 || od1 !== 8'h11 || ov1 !== 1'b1 || och1 !== 2'd0) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: got u0 d=%h v=%b u1 d=%h v=%b ch=%0d want d=11 v=1 ch=0",
                         i, od0, ov0, od1, ov1, och1);
            end
        end
        t_rdy[0] = 1'b1; t_rdy[1] = 1'b1;
        t_v[0] = 4'b1111; t_v[1] = 4'b1111; t_sel[0] = 2'd3;
        d0 = $urandom; d1 = $urandom;
        t_data[0] = d0; t_data[1] = d1;
        @(negedge CLK);
        n_cmp++;
        if (ir0 !== 4'b1000 || ir1 !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_release_ready: got u0=%b u1=%b want u0=1000 u1=0010", ir0, ir1);
        end
        tick();
        n_cmp++;
        if (od0 !== d0[31:24] || ov0 !== 1'b1 || od1 !== d1[15:8] || ov1 !== 1'b1 || och1 !== 2'd1) begin
            n_err++;
            $display("FAIL bp_release_out: got u0 d=%h v=%b u1 d=%h v=%b ch=%0d want u0 d=%h v=1 u1 d=%h v=1 ch=1",
                     od0, ov0, od1, ov1, och1, d0[31:24], d1[15:8]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 3; d++) begin
                t_v[d]    = (d == 2) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
                t_data[d] = $urandom;
                t_sel[d]  = 2'($urandom_range(0, 3));
                t_rdy[d]  = ($urandom_range(0, 3) != 0);
            end
            @(negedge CLK);
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs_ready(d) !== exp_ready(d)) begin
                    n_err++;
                    $display("FAIL rand_ready dut%0d cyc%0d: got %b want %b", d, i, obs_ready(d), exp_ready(d));
                end
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs_valid(d) !== m_valid[d] || obs_data(d) !== m_data[d] || obs_ch(d) !== 2'(m_ch[d])) begin
                    n_err++;
                    $display("FAIL rand_out dut%0d cyc%0d: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                             d, i, obs_valid(d), obs_data(d), obs_ch(d), m_valid[d], m_data[d], m_ch[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sel_basic();
        test_sel_unselected();
        test_rr_fairness();
        test_rr_skip_wrap();
        test_backpressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
